// File: rtl/decode_issue_queue_if.sv
// Fetch-side and issue-side handshake bundle for the decode issue queue.
// The queue attaches to the slave modport; the producer/consumer side uses master.
interface decode_issue_queue_if #(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned ISSUE_WIDTH = 2
);
    logic [FETCH_WIDTH-1:0]        in_valid;
    logic [FETCH_WIDTH-1:0][31:0]  in_instr;
    logic [FETCH_WIDTH-1:0][31:0]  in_pc;
    logic [FETCH_WIDTH-1:0][2:0]   in_exc;
    logic                          in_ready;

    logic [ISSUE_WIDTH-1:0]        out_valid;
    logic [ISSUE_WIDTH-1:0][31:0]  out_instr;
    logic [ISSUE_WIDTH-1:0][31:0]  out_pc;
    logic [ISSUE_WIDTH-1:0][2:0]   out_exc;
    logic [ISSUE_WIDTH-1:0]        out_delay_slot;
    logic [ISSUE_WIDTH-1:0]        out_ready;

    modport master (
        output in_valid, in_instr, in_pc, in_exc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_exc, out_delay_slot
    );

    modport slave (
        input  in_valid, in_instr, in_pc, in_exc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_exc, out_delay_slot
    );
endinterface

// File: rtl/decode_issue_queue.sv
// Circular decode/issue queue: accepts up to FETCH_WIDTH MIPS instructions per cycle,
// presents up to ISSUE_WIDTH head entries, tags delay slots and can hold a branch for its slot.
module decode_issue_queue #(
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned FETCH_WIDTH     = 2,
    parameter int unsigned ISSUE_WIDTH     = 2,
    parameter int unsigned PAIR_DELAY_SLOT = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    decode_issue_queue_if.slave   io
);
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned READY_MAX = DEPTH - FETCH_WIDTH;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             prev_branch;

    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      pc_mem    [DEPTH];
    logic [2:0]       exc_mem   [DEPTH];
    logic [DEPTH-1:0] ds_mem;
    logic [DEPTH-1:0] br_mem;

    logic                   push_en;
    logic [CNT_W-1:0]       n_push;
    logic [CNT_W-1:0]       n_pop;
    logic [FETCH_WIDTH-1:0] wr_en;
    logic [FETCH_WIDTH-1:0] wr_ds;
    logic [FETCH_WIDTH-1:0] wr_br;
    logic [PTR_W-1:0]       wr_ptr [FETCH_WIDTH];
    logic                   prev_branch_nxt;
    logic [ISSUE_WIDTH-1:0] valid_c;
    logic [PTR_W-1:0]       rd_ptr [ISSUE_WIDTH];
    logic                   issue_stop;

    // MIPS branch/jump class: REGIMM, J, JAL, BEQ, BNE, BLEZ, BGTZ, and SPECIAL JR/JALR
    function automatic logic is_branch(input logic [5:0] op, input logic [5:0] fn);
        return (op >= 6'd1 && op <= 6'd7) ||
               (op == 6'd0 && (fn == 6'b001000 || fn == 6'b001001));
    endfunction

    // Admission depends only on registered occupancy so pops never feed in_ready
    assign io.in_ready = (count <= CNT_W'(READY_MAX));
    assign push_en     = io.in_ready && !flush;

    // Slot placement and delay-slot tagging for the incoming fetch group
    always_comb begin : push_side
        n_push          = '0;
        wr_en           = '0;
        wr_ds           = '0;
        wr_br           = '0;
        prev_branch_nxt = prev_branch;
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            wr_ptr[i] = tail + PTR_W'(n_push);
            wr_br[i]  = is_branch(io.in_instr[i][31:26], io.in_instr[i][5:0]);
            if (push_en && io.in_valid[i]) begin
                wr_en[i]        = 1'b1;
                wr_ds[i]        = prev_branch_nxt;
                prev_branch_nxt = wr_br[i];
                n_push          = n_push + CNT_W'(1);
            end
        end
    end

    // Head window: stops at the first empty slot or at a branch whose delay slot cannot join it
    always_comb begin : issue_side
        n_pop             = '0;
        issue_stop        = flush;
        valid_c           = '0;
        io.out_valid      = '0;
        io.out_instr      = '0;
        io.out_pc         = '0;
        io.out_exc        = '0;
        io.out_delay_slot = '0;
        for (int k = 0; k < int'(ISSUE_WIDTH); k++) begin
            rd_ptr[k] = head + PTR_W'(k);
            if (!issue_stop && count > CNT_W'(k)) begin
                if (PAIR_DELAY_SLOT != 0 && br_mem[rd_ptr[k]] &&
                    (count <= CNT_W'(k + 1) || k + 1 >= int'(ISSUE_WIDTH)))
                    issue_stop = 1'b1;
                else
                    valid_c[k] = 1'b1;
            end else begin
                issue_stop = 1'b1;
            end
            if (valid_c[k]) begin
                io.out_valid[k]      = 1'b1;
                io.out_instr[k]      = instr_mem[rd_ptr[k]];
                io.out_pc[k]         = pc_mem[rd_ptr[k]];
                io.out_exc[k]        = exc_mem[rd_ptr[k]];
                io.out_delay_slot[k] = ds_mem[rd_ptr[k]];
                if (io.out_ready[k])
                    n_pop = n_pop + CNT_W'(1);
            end
        end
    end

    // Entry payload storage; contents are never visible unless the slot is valid
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            if (wr_en[i]) begin
                instr_mem[wr_ptr[i]] <= io.in_instr[i];
                pc_mem[wr_ptr[i]]    <= io.in_pc[i];
                exc_mem[wr_ptr[i]]   <= io.in_exc[i];
                ds_mem[wr_ptr[i]]    <= wr_ds[i];
                br_mem[wr_ptr[i]]    <= wr_br[i];
            end
        end
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            prev_branch <= 1'b0;
        end else if (flush) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            prev_branch <= 1'b0;
        end else begin
            head        <= head + PTR_W'(n_pop);
            tail        <= tail + PTR_W'(n_push);
            count       <= count + n_push - n_pop;
            prev_branch <= prev_branch_nxt;
        end
    end
endmodule

// File: tb/tb_decode_issue_queue.sv
// Self-checking bench for decode_issue_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_decode_issue_queue;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned FW    = 2;
    localparam int unsigned IW    = 2;

    localparam logic [31:0] ADDU = 32'h00221821;
    localparam logic [31:0] ORI  = 32'h34210005;
    localparam logic [31:0] BEQ  = 32'h10220003;
    localparam logic [31:0] SW   = 32'hAC220000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  exc;
        logic        ds;
    } ent_t;

    logic clk;
    logic resetn;
    logic flush;
    int   n_checks = 0;
    int   n_fail   = 0;

    decode_issue_queue_if #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW)) bus ();
    decode_issue_queue_if #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(1))  bus1 ();

    decode_issue_queue #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .PAIR_DELAY_SLOT(1)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .io(bus)
    );
    decode_issue_queue #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(1), .PAIR_DELAY_SLOT(0)) dut1 (
        .clk(clk), .resetn(resetn), .flush(flush), .io(bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Prefix-closed handshake protocol
    always @(posedge clk) begin
        if (resetn) begin
            assert ((bus.in_valid & (bus.in_valid + 1'b1)) == 0)
                else $error("protocol violation: in_valid not prefix-closed %b", bus.in_valid);
            assert ((bus.out_ready & (bus.out_ready + 1'b1)) == 0)
                else $error("protocol violation: out_ready not prefix-closed %b", bus.out_ready);
        end
    end

    // Reference model: program-ordered list of queued entries
    ent_t            q[$];
    logic            prev_br;
    logic [IW-1:0]   exp_valid;
    ent_t            exp_ent [IW];
    logic            exp_ready;

    function automatic logic is_br(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        return (op inside {6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b000110, 6'b000111}) ||
               (op == 6'b000000 && (fn == 6'b001000 || fn == 6'b001001));
    endfunction

    task automatic model_expect();
        bit stop;
        stop = flush;
        exp_ready = (int'(DEPTH) - q.size()) >= int'(FW);
        exp_valid = '0;
        for (int k = 0; k < int'(IW); k++) begin
            exp_ent[k] = '0;
            if (stop || k >= q.size())
                stop = 1;
            else if (is_br(q[k].instr) && (q.size() <= k + 1 || k + 1 >= int'(IW)))
                stop = 1;
            else begin
                exp_valid[k] = 1'b1;
                exp_ent[k]   = q[k];
            end
        end
    endtask

    task automatic model_advance();
        int pops;
        pops = 0;
        if (flush) begin
            q.delete();
            prev_br = 1'b0;
            return;
        end
        for (int k = 0; k < int'(IW); k++)
            if (exp_valid[k] && bus.out_ready[k]) pops++;
        repeat (pops) void'(q.pop_front());
        if (exp_ready) begin
            for (int i = 0; i < int'(FW); i++) begin
                if (bus.in_valid[i]) begin
                    ent_t e;
                    e.instr = bus.in_instr[i];
                    e.pc    = bus.in_pc[i];
                    e.exc   = bus.in_exc[i];
                    e.ds    = prev_br;
                    q.push_back(e);
                    prev_br = is_br(bus.in_instr[i]);
                end
            end
        end
    endtask

    task automatic drive(input logic [FW-1:0] iv, input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1, input logic [IW-1:0] ordy);
        bus.in_valid    = iv;
        bus.in_instr[0] = i0;
        bus.in_pc[0]    = p0;
        bus.in_instr[1] = i1;
        bus.in_pc[1]    = p1;
        bus.in_exc      = '0;
        bus.out_ready   = ordy;
    endtask

    task automatic settle();
        @(negedge clk);
        model_expect();
    endtask

    task automatic advance();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        flush = 1'b1;
        drive('0, '0, '0, '0, '0, '0);
        settle();
        advance();
        flush = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        case ($urandom_range(0, 3))
            0:       return {6'b000100, 26'($urandom)};
            1:       return {6'b000000, 20'($urandom), 5'b00100, 1'($urandom)};
            2:       return {6'b000000, 20'($urandom), 6'b100001};
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        resetn = 1'b1;
        flush  = 1'b0;
        drive('0, '0, '0, '0, '0, '0);
        bus1.in_valid = '0; bus1.in_instr = '0; bus1.in_pc = '0; bus1.in_exc = '0; bus1.out_ready = '0;
        q.delete();
        prev_br = 1'b0;
        #1 resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 00", bus.out_valid); end
        n_checks++; if (dut.count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", dut.count); end
        n_checks++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid1: got %b expected 0", bus1.out_valid); end
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_basic();
        clear();
        drive(2'b11, ADDU, 32'h100, ORI, 32'h104, 2'b00);
        settle();
        n_checks++; if (bus.out_valid !== 2'b00) begin n_fail++; $display("FAIL basic_no_bypass: got %b expected 00", bus.out_valid); end
        advance();
        drive(2'b00, '0, '0, '0, '0, 2'b00);
        settle();
        n_checks++; if (bus.out_valid !== 2'b11) begin n_fail++; $display("FAIL basic_valid: got %b expected 11", bus.out_valid); end
        n_checks++; if (bus.out_pc !== {32'h104, 32'h100}) begin n_fail++; $display("FAIL basic_pc: got %h expected %h", bus.out_pc, {32'h104, 32'h100}); end
        n_checks++; if (bus.out_instr !== {ORI, ADDU}) begin n_fail++; $display("FAIL basic_instr: got %h expected %h", bus.out_instr, {ORI, ADDU}); end
        n_checks++; if (bus.out_delay_slot !== 2'b00) begin n_fail++; $display("FAIL basic_ds: got %b expected 00", bus.out_delay_slot); end
        n_checks++; if (dut.count !== 4'd2) begin n_fail++; $display("FAIL basic_count: got %0d expected 2", dut.count); end
        advance();
    endtask

    task automatic test_branch_hold();
        clear();
        drive(2'b11, ADDU, 32'h100, BEQ, 32'h104, 2'b00);
        advance();
        drive(2'b00, '0, '0, '0, '0, 2'b00);
        settle();
        n_checks++; if (bus.out_valid !== 2'b01) begin n_fail++; $display("FAIL hold_valid: got %b expected 01", bus.out_valid); end
        advance();
        drive(2'b11, SW, 32'h108, ADDU, 32'h10C, 2'b01);
        settle();
        n_checks++; if (bus.out_valid !== 2'b01 || bus.out_pc[0] !== 32'h100) begin
            n_fail++; $display("FAIL hold_pop_addu: got valid %b pc %h expected 01 00000100", bus.out_valid, bus.out_pc[0]); end
        advance();
        drive(2'b00, '0, '0, '0, '0, 2'b11);
        settle();
        n_checks++; if (bus.out_valid !== 2'b11) begin n_fail++; $display("FAIL pair_valid: got %b expected 11", bus.out_valid); end
        n_checks++; if (bus.out_instr !== {SW, BEQ}) begin n_fail++; $display("FAIL pair_instr: got %h expected %h", bus.out_instr, {SW, BEQ}); end
        n_checks++; if (bus.out_delay_slot !== 2'b10) begin n_fail++; $display("FAIL pair_ds: got %b expected 10", bus.out_delay_slot); end
        advance();
        drive(2'b00, '0, '0, '0, '0, 2'b00);
        settle();
        n_checks++; if (bus.out_valid !== 2'b01 || bus.out_pc[0] !== 32'h10C || bus.out_delay_slot[0] !== 1'b0) begin
            n_fail++; $display("FAIL after_pair: got valid %b pc %h ds %b expected 01 0000010c 0", bus.out_valid, bus.out_pc[0], bus.out_delay_slot[0]); end
        advance();
    endtask

    task automatic test_full_wrap();
        clear();
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, ADDU, 32'h1000 + 32'(8 * c), ADDU, 32'h1004 + 32'(8 * c), 2'b00);
            settle();
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b expected 1", c, bus.in_ready); end
            advance();
        end
        drive(2'b11, ADDU, 32'h2000, ADDU, 32'h2004, 2'b00);
        settle();
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", bus.in_ready); end
        n_checks++; if (dut.count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d expected 8", dut.count); end
        advance();
        drive(2'b00, '0, '0, '0, '0, 2'b11);
        settle();
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL pop_no_raise: got %b expected 0", bus.in_ready); end
        n_checks++; if (bus.out_pc !== {32'h1004, 32'h1000}) begin n_fail++; $display("FAIL drain_first: got %h expected %h", bus.out_pc, {32'h1004, 32'h1000}); end
        advance();
        for (int j = 0; j < 8; j++) begin
            drive(2'b11, ADDU, 32'h1020 + 32'(8 * j), ADDU, 32'h1024 + 32'(8 * j), 2'b11);
            settle();
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready[%0d]: got %b expected 1", j, bus.in_ready); end
            n_checks++; if (bus.out_valid !== 2'b11 || bus.out_pc !== {32'h100C + 32'(8 * j), 32'h1008 + 32'(8 * j)}) begin
                n_fail++; $display("FAIL wrap_order[%0d]: got valid %b pc %h expected 11 %h", j, bus.out_valid, bus.out_pc,
                                   {32'h100C + 32'(8 * j), 32'h1008 + 32'(8 * j)}); end
            advance();
        end
    endtask

    task automatic test_simul_flush();
        clear();
        drive(2'b11, ADDU, 32'h500, ADDU, 32'h504, 2'b00); advance();
        drive(2'b11, ADDU, 32'h508, ADDU, 32'h50C, 2'b00); advance();
        drive(2'b01, ADDU, 32'h510, ADDU, 32'h0, 2'b00);   advance();
        drive(2'b11, ADDU, 32'h514, BEQ, 32'h518, 2'b11);
        settle();
        n_checks++; if (dut.count !== 4'd5 || bus.out_valid !== 2'b11) begin
            n_fail++; $display("FAIL pushpop_pre: got count %0d valid %b expected 5 11", dut.count, bus.out_valid); end
        advance();
        flush = 1'b1;
        drive(2'b11, ADDU, 32'h600, ADDU, 32'h604, 2'b11);
        settle();
        n_checks++; if (dut.count !== 4'd5) begin n_fail++; $display("FAIL pushpop_count: got %0d expected 5", dut.count); end
        n_checks++; if (bus.out_valid !== 2'b00) begin n_fail++; $display("FAIL flush_valid: got %b expected 00", bus.out_valid); end
        advance();
        flush = 1'b0;
        drive(2'b11, ADDU, 32'h700, ADDU, 32'h704, 2'b00);
        settle();
        n_checks++; if (dut.count !== 4'd0 || dut.prev_branch !== 1'b0) begin
            n_fail++; $display("FAIL flush_state: got count %0d prev_branch %b expected 0 0", dut.count, dut.prev_branch); end
        advance();
        drive(2'b00, '0, '0, '0, '0, 2'b00);
        settle();
        n_checks++; if (bus.out_valid !== 2'b11 || bus.out_pc[0] !== 32'h700 || bus.out_delay_slot !== 2'b00) begin
            n_fail++; $display("FAIL post_flush: got valid %b pc %h ds %b expected 11 00000700 00", bus.out_valid, bus.out_pc[0], bus.out_delay_slot); end
        advance();
    endtask

    task automatic test_async_reset();
        clear();
        for (int c = 0; c < 3; c++) begin
            drive(2'b11, ADDU, 32'h800 + 32'(8 * c), ADDU, 32'h804 + 32'(8 * c), 2'b00);
            advance();
        end
        drive(2'b11, ADDU, 32'h818, ADDU, 32'h81C, 2'b11);
        advance();
        drive(2'b00, '0, '0, '0, '0, 2'b00);
        #1 resetn = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 2'b00 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL async_reset_out: got valid %b ready %b expected 00 1", bus.out_valid, bus.in_ready); end
        n_checks++; if (dut.count !== 4'd0) begin n_fail++; $display("FAIL async_reset_count: got %0d expected 0", dut.count); end
        resetn = 1'b1;
        q.delete();
        prev_br = 1'b0;
        drive(2'b11, ORI, 32'h300, ADDU, 32'h304, 2'b00);
        settle();
        advance();
        drive(2'b00, '0, '0, '0, '0, 2'b00);
        settle();
        n_checks++; if (bus.out_valid !== 2'b11 || bus.out_pc[0] !== 32'h300 || bus.out_instr[0] !== ORI) begin
            n_fail++; $display("FAIL async_reset_resume: got valid %b pc %h expected 11 00000300", bus.out_valid, bus.out_pc[0]); end
        advance();
    endtask

    task automatic test_single_issue();
        bus1.in_valid    = 2'b11;
        bus1.in_instr[0] = BEQ;  bus1.in_pc[0] = 32'h400;
        bus1.in_instr[1] = ADDU; bus1.in_pc[1] = 32'h404;
        bus1.in_exc      = '0;
        bus1.out_ready   = 1'b1;
        settle();
        n_checks++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b expected 0", bus1.out_valid); end
        advance();
        bus1.in_valid = '0;
        settle();
        n_checks++; if (bus1.out_valid !== 1'b1 || bus1.out_pc[0] !== 32'h400 || bus1.out_delay_slot[0] !== 1'b0) begin
            n_fail++; $display("FAIL single_branch: got valid %b pc %h ds %b expected 1 00000400 0", bus1.out_valid, bus1.out_pc[0], bus1.out_delay_slot[0]); end
        advance();
        settle();
        n_checks++; if (bus1.out_valid !== 1'b1 || bus1.out_pc[0] !== 32'h404 || bus1.out_delay_slot[0] !== 1'b1) begin
            n_fail++; $display("FAIL single_slot: got valid %b pc %h ds %b expected 1 00000404 1", bus1.out_valid, bus1.out_pc[0], bus1.out_delay_slot[0]); end
        advance();
        bus1.out_ready = 1'b0;
        settle();
        n_checks++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b expected 0", bus1.out_valid); end
        advance();
    endtask

    task automatic test_random();
        logic [31:0] pc;
        clear();
        pc = 32'h4000;
        for (int c = 0; c < 400; c++) begin
            int ni;
            int no;
            ni = $urandom_range(0, FW);
            no = $urandom_range(0, IW);
            flush = ($urandom_range(0, 31) == 0);
            bus.in_valid  = FW'((1 << ni) - 1);
            bus.out_ready = IW'((1 << no) - 1);
            for (int i = 0; i < int'(FW); i++) begin
                bus.in_instr[i] = rand_instr();
                bus.in_pc[i]    = pc;
                bus.in_exc[i]   = 3'($urandom);
                pc              = pc + 32'd4;
            end
            settle();
            n_checks++; if (bus.in_ready !== exp_ready) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, bus.in_ready, exp_ready); end
            n_checks++; if (bus.out_valid !== exp_valid) begin
                n_fail++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, bus.out_valid, exp_valid); end
            for (int k = 0; k < int'(IW); k++) begin
                if (exp_valid[k]) begin
                    n_checks++;
                    if ({bus.out_instr[k], bus.out_pc[k], bus.out_exc[k], bus.out_delay_slot[k]} !== exp_ent[k]) begin
                        n_fail++;
                        $display("FAIL rand_slot%0d[%0d]: got %h expected %h", k, c,
                                 {bus.out_instr[k], bus.out_pc[k], bus.out_exc[k], bus.out_delay_slot[k]}, exp_ent[k]);
                    end
                end
            end
            advance();
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch_hold();
        test_full_wrap();
        test_simul_flush();
        test_async_reset();
        test_single_issue();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
